restoring_div_16: RTL and testbench

//   Sequential signed divider: inverse of the 16-bit multiplier in the CPU datapath.

---
 rtl/dsd_arith_pkg.sv | 13 +
 rtl/udiv_restoring_core.sv | 62 ++++++
 rtl/restoring_div_16.sv | 117 +++++++++++
 tb/tb_restoring_div_16.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dsd_arith_pkg.sv
// Shared arithmetic definitions for the sequential multiply/divide units.
// Holds the sequencing states and the default datapath width.
package dsd_arith_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } arith_state_e;

endpackage

// File: rtl/udiv_restoring_core.sv
// Unsigned iterative restoring divider: one quotient bit per iter_i cycle.
// The caller sequences exactly WIDTH iterations after a load.
module udiv_restoring_core
    import dsd_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             iter_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             done_iter_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    // Partial remainder carries one extra bit so the shifted value cannot overflow.
    logic [WIDTH:0]   r_q;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CntW-1:0]  count_q;

    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        d_ext   = {1'b0, d_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
        end else if (load_i) begin
            r_q     <= '0;
            q_q     <= dividend_i;
            d_q     <= divisor_i;
            count_q <= '0;
        end else if (iter_i) begin
            if (r_shift >= d_ext) begin
                r_q <= r_shift - d_ext;
                q_q <= {q_q[WIDTH-2:0], 1'b1};
            end else begin
                r_q <= r_shift;
                q_q <= {q_q[WIDTH-2:0], 1'b0};
            end
            count_q <= count_q + 1'b1;
        end
    end

    // High during the cycle whose edge performs the final iteration.
    assign done_iter_o = (count_q == CntW'(WIDTH - 1));
    assign quotient_o  = q_q;
    assign remainder_o = r_q[WIDTH-1:0];

endmodule

// File: rtl/restoring_div_16.sv
// Signed sequential divider: sign handling, special cases and start/done handshake
// around the unsigned restoring core.
module restoring_div_16
    import dsd_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    arith_state_e     state_q;
    logic [WIDTH-1:0] dividend_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] core_quot;
    logic [WIDTH-1:0] core_rem;
    logic             core_done_iter;
    logic             core_load;
    logic             core_iter;
    logic             divisor_zero;

    // An unsigned W-bit magnitude is exact even for -2^(W-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

    always_comb begin
        dividend_mag = mag(dividend);
        divisor_mag  = mag(divisor);
        divisor_zero = (divisor == '0);
        core_load    = (state_q == StIdle) && start && !divisor_zero;
        core_iter    = (state_q == StCalc);
    end

    udiv_restoring_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .load_i      (core_load),
        .iter_i      (core_iter),
        .dividend_i  (dividend_mag),
        .divisor_i   (divisor_mag),
        .quotient_o  (core_quot),
        .remainder_o (core_rem),
        .done_iter_o (core_done_iter)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            dividend_q  <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        dividend_q  <= dividend;
                        neg_quot_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_q   <= dividend[WIDTH-1];
                        dz_q        <= divisor_zero;
                        ovf_q       <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                       (divisor == '1);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= divisor_zero ? StFix : StCalc;
                    end
                end
                StCalc: begin
                    if (core_done_iter) state_q <= StFix;
                end
                StFix: begin
                    if (dz_q) begin
                        quotient    <= '1;
                        remainder   <= dividend_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= neg_quot_q ? ('0 - core_quot) : core_quot;
                        remainder <= neg_rem_q ? ('0 - core_rem) : core_rem;
                        overflow  <= ovf_q;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_16.sv
// Scoreboard bench for restoring_div_16: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_restoring_div_16;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    restoring_div_16 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every done, also checks that done never lasts two cycles.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) check("done_one_cycle", {31'b0, done}, 32'd0);
            prev_done = done;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {16'b0, quotient}, {16'b0, e.q});
                    check("remainder", {16'b0, remainder}, {16'b0, e.r});
                    check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
                    check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                    check("busy_at_done", {31'b0, busy}, 32'd0);
                    check("latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Called at a negedge; the next posedge is the accepting edge E0.
    // Latency is measured from this negedge: done after E(n) is seen n+1 counts later.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input logic [15:0] r, input logic dz, input logic ovf, input int lat);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.q = q; e.r = r; e.dz = dz; e.ovf = ovf; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        sb.delete();
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                      input logic [15:0] r, input logic dz, input logic ovf, input int lat);
        @(negedge clk);
        issue(a, b, q, r, dz, ovf, lat);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quotient"}, {16'b0, quotient}, 32'd0);
        check({tag, "_remainder"}, {16'b0, remainder}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_dz"}, {31'b0, div_by_zero}, 32'd0);
        check({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 18);
        op(-16'sd100, 16'd7, -16'sd14, -16'sd2, 1'b0, 1'b0, 18);
        op(16'd100, -16'sd7, -16'sd14, 16'd2, 1'b0, 1'b0, 18);
        op(-16'sd100, -16'sd7, 16'd14, -16'sd2, 1'b0, 1'b0, 18);
        op(16'd7, 16'd100, 16'd0, 16'd7, 1'b0, 1'b0, 18);
        op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 2);
        op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1, 18);
        op(16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0, 1'b0, 18);

        // Start pulse at E5 with different operands must be ignored.
        @(negedge clk);
        issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 18);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_mid_op", {31'b0, busy}, 32'd1);
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start held high across done: second op accepted on the done cycle.
        @(negedge clk);
        issue(16'd500, -16'sd9, -16'sd55, 16'd5, 1'b0, 1'b0, 18);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        issue(-16'sd7, 16'd2, -16'sd3, -16'sd1, 1'b0, 1'b0, 18);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset at E8 of an operation; its result must never appear.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd300;
        divisor  = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 18);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
